load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//   Sequences CPU load/store requests onto the single-port data memory. Sits
//   directly upstream of the data memory: the execute stage hands it one request
//   at a time over a valid/ready handshake. It drives the memory's cmd/addr/data
//   lines and returns load data over a valid/ready response channel. mem_cmd is
//   held at READ whenever idle, so the memory never sees a spurious write.
// PARAMETERS
//   AW      8   address width (mem_addr, req_addr)
//   DW      8   data width
//   DEPTH   4   number of implemented memory words; addresses >= DEPTH are out of range
//   RD_LAT  1   cycles from the memory sampling a read command to mem_rdata being valid (>=1)
// PORTS
//   clk           in   1    clock, all logic on posedge
//   rst_n         in   1    synchronous active-low reset
//   req_valid     in   1    request present
//   req_ready     out  1    unit can accept a request
//   req_we        in   1    1 = store, 0 = load
//   req_addr      in   AW   word address
//   req_wdata     in   DW   store data
//   rsp_valid     out  1    load response present
//   rsp_ready     in   1    consumer takes response
//   rsp_rdata     out  DW   load data (0 when rsp_err)
//   rsp_err       out  1    load address was out of range
//   mem_cmd       out  1    0 = read, 1 = write (to the data memory's cmd input)
//   mem_addr      out  AW   memory address
//   mem_wdata     out  DW   write data onto the shared data bus
//   mem_wdata_oe  out  1    tristate enable for mem_wdata at the top level
//   mem_rdata     in   DW   read data from the shared data bus
//   busy          out  1    state != IDLE
// BEHAVIOUR
//   - Registered outputs. On reset: state IDLE.
//     - Output values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_cmd=0,
//       mem_addr=0, mem_wdata=0, mem_wdata_oe=0, busy=0.
//   - FSM: IDLE -> ISSUE -> (store) IDLE | (load) WAIT -> RESP -> IDLE.
//   - IDLE: req_ready=1. On edge with req_valid&&req_ready: latch we/addr/wdata.
//     - Latch range flag: addr >= DEPTH.
//     - Next state ISSUE. req_ready=0 in every state other than IDLE.
//   - ISSUE (exactly 1 cycle): mem_addr=latched addr.
//     - In-range store: mem_cmd=1, mem_wdata=wdata, mem_wdata_oe=1. Memory writes at
//       the closing edge, then the FSM returns to IDLE. Stores are posted; they
//       produce no response.
//     - Out-of-range store: mem_cmd stays 0 and the store is silently dropped.
//     - Load: mem_cmd=0. Load counter to RD_LAT, then go to WAIT.
//   - WAIT: counter decrements each cycle. On the edge where the counter reaches 1,
//     capture mem_rdata into rsp_rdata (forced to 0 and rsp_err=1 if out of range),
//     then go to RESP.
//   - RESP: rsp_valid=1 with rsp_rdata/rsp_err stable until an edge with rsp_ready=1.
//     Then rsp_valid=0 and the FSM returns to IDLE.
//   - mem_cmd=1 and mem_wdata_oe=1 only during an in-range store's ISSUE cycle.
//     Otherwise mem_cmd=0 and mem_wdata_oe=0. mem_addr holds its last value.
//   - Latency, accept at edge E0:
//     - Store: written at E1; req_ready high again after E1 (1 store / 2 cycles).
//     - Load: rsp_valid rises after edge E0+1+RD_LAT.
//     - Back-to-back loads with rsp_ready held 1: one load every RD_LAT+3 cycles.
//   - No new request is accepted while a response is pending. No reordering.
//   - Reset mid-operation (any state): at the edge with rst_n=0 the FSM aborts to IDLE.
//     - Any pending response is discarded. mem_cmd=0 from that edge.
//     - A store in ISSUE at that edge is not guaranteed to complete.
//   - req_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
// STRUCTURE
//   - Shared package cpu_pkg:
//     - MEM_CMD_READ=1'b0, MEM_CMD_WRITE=1'b1.
//     - lsu_state_t {IDLE, ISSUE, WAIT, RESP}.
//   - Single module, no sub-module. The tristate buffer on the data bus lives at the
//     CPU top level, driven by mem_wdata/mem_wdata_oe.
// TESTING (DEPTH=4, RD_LAT=1, memory preloaded with [0]=0x00,[1]=0x01,[2]=0x02,[3]=0x03)
//   1. Load addr 2, rsp_ready=1 -> rsp_valid rises 2 edges after accept, rsp_rdata=0x02,
//      rsp_err=0; mem_cmd never 1.
//   2. Store 0xA5 to addr 1, then load addr 1 -> mem_cmd=1 for exactly one cycle,
//      mem_addr=1; load returns 0xA5.
//   3. Store 0x77 to addr 6, then load addr 6 -> mem_cmd stays 0; load returns
//      rsp_rdata=0x00, rsp_err=1; memory words unchanged.
//   4. Load addr 3 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata=0x03 held;
//      req_ready=0; a second req_valid is not accepted until after the rsp_ready edge.
//   5. Assert rst_n=0 during WAIT of a load -> next edge: rsp_valid=0, req_ready=1,
//      busy=0, mem_cmd=0; no response ever appears.
//   6. Continuous load stream (addrs 0,1,2,3), rsp_ready=1 -> responses 0x00..0x03
//      in order, one per 4 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: data-memory command encoding and LSU state type.
package cpu_pkg;

  localparam logic MEM_CMD_READ  = 1'b0;
  localparam logic MEM_CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: sequences one request at a time onto the single-port data
// memory and returns load data over a valid/ready response channel.
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wdata_oe,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // Counter wide enough to hold RD_LAT (at least one bit).
  localparam int unsigned CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  lsu_state_t    state_q, state_d;
  logic          we_q, we_d;
  logic          oor_q, oor_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          req_ready_d;
  logic          rsp_valid_d;
  logic [DW-1:0] rsp_rdata_d;
  logic          rsp_err_d;
  logic          mem_cmd_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic          mem_wdata_oe_d;
  logic          busy_d;

  logic          req_oor_c;

  // Request address falls outside the implemented memory words.
  assign req_oor_c = (32'(req_addr) >= DEPTH);

  // Next-state and next-output logic; the output registers load these values.
  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    oor_d          = oor_q;
    cnt_d          = cnt_q;
    req_ready_d    = req_ready;
    rsp_valid_d    = rsp_valid;
    rsp_rdata_d    = rsp_rdata;
    rsp_err_d      = rsp_err;
    mem_cmd_d      = MEM_CMD_READ;
    mem_addr_d     = mem_addr;
    mem_wdata_d    = mem_wdata;
    mem_wdata_oe_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          we_d        = req_we;
          oor_d       = req_oor_c;
          mem_addr_d  = req_addr;
          req_ready_d = 1'b0;
          state_d     = ISSUE;
          if (req_we) begin
            mem_wdata_d = req_wdata;
            // Out-of-range stores are dropped: the bus stays in read mode.
            if (!req_oor_c) begin
              mem_cmd_d      = MEM_CMD_WRITE;
              mem_wdata_oe_d = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          // Stores are posted; the memory wrote at the edge closing ISSUE.
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d   = CW'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          rsp_rdata_d = oor_q ? '0 : mem_rdata;
          rsp_err_d   = oor_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      oor_q        <= 1'b0;
      cnt_q        <= '0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      mem_cmd      <= MEM_CMD_READ;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wdata_oe <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      oor_q        <= oor_d;
      cnt_q        <= cnt_d;
      req_ready    <= req_ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rsp_rdata_d;
      rsp_err      <= rsp_err_d;
      mem_cmd      <= mem_cmd_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      mem_wdata_oe <= mem_wdata_oe_d;
      busy         <= busy_d;
    end
  end

endmodule
